// File: rtl/boot_region_copier.sv
`default_nettype none
// boot_region_copier: boot-time byte copier from a parametrised table of flash regions into SD-RAM.
// Build macro BOOT_REGION_COPIER_CHECKSUM_EN adds a 16-bit running sum of all bytes read in a pass.
module boot_region_copier #(
    parameter int                         REGION_COUNT    = 3,
    parameter logic [24*REGION_COUNT-1:0] FLASH_ADDR_LIST = {24'h1F_0000, 24'h12_0000, 24'h10_0000},
    parameter logic [24*REGION_COUNT-1:0] RAM_ADDR_LIST   = {24'h77_E000, 24'h72_0000, 24'h70_0000},
    parameter logic [24*REGION_COUNT-1:0] SIZE_LIST       = {24'h00_2000, 24'h00_4000, 24'h02_0000}
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic [REGION_COUNT-1:0] REGION_EN,
    output logic                    FLASH_REQ,
    output logic [23:0]             FLASH_ADDR,
    input  logic                    FLASH_ACK,
    input  logic [7:0]              FLASH_DATA,
    output logic                    RAM_REQ,
    output logic [23:0]             RAM_ADDR,
    output logic [7:0]              RAM_DATA,
    input  logic                    RAM_ACK,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [2:0]              REGION,
    output logic [15:0]             CHECKSUM
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_FRD    = 3'd2,
        S_RWR    = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(REGION_COUNT - 1);

    state_t                  state_q, state_d;
    logic [REGION_COUNT-1:0] en_q, en_d;
    logic [2:0]              idx_q, idx_d;
    logic [23:0]             src_q, src_d;
    logic [23:0]             dst_q, dst_d;
    logic [23:0]             cnt_q, cnt_d;
    logic [7:0]              byte_q, byte_d;
    logic                    freq_q, freq_d;
    logic                    rreq_q, rreq_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    sel_en;
    logic [23:0]             sel_src;
    logic [23:0]             sel_dst;
    logic [23:0]             sel_size;

    // Table lookup of the entry addressed by the current region index.
    always_comb begin
        sel_en   = 1'b0;
        sel_src  = '0;
        sel_dst  = '0;
        sel_size = '0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            if (idx_q == 3'(i)) begin
                sel_en   = en_q[i];
                sel_src  = FLASH_ADDR_LIST[24*i +: 24];
                sel_dst  = RAM_ADDR_LIST[24*i +: 24];
                sel_size = SIZE_LIST[24*i +: 24];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        idx_d   = idx_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        freq_d  = freq_q;
        rreq_d  = rreq_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SELECT;
                    en_d    = REGION_EN;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_SELECT: begin
                if (sel_en && (sel_size != 24'd0)) begin
                    src_d   = sel_src;
                    dst_d   = sel_dst;
                    cnt_d   = sel_size;
                    freq_d  = 1'b1;
                    state_d = S_FRD;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_FRD: begin
                if (FLASH_ACK) begin
                    byte_d  = FLASH_DATA;
                    freq_d  = 1'b0;
                    rreq_d  = 1'b1;
                    state_d = S_RWR;
                end
            end
            S_RWR: begin
                if (RAM_ACK) begin
                    src_d  = src_q + 24'd1;
                    dst_d  = dst_q + 24'd1;
                    cnt_d  = cnt_q - 24'd1;
                    rreq_d = 1'b0;
                    // cnt_q==1 means the byte just written was the last of the region.
                    if (cnt_q != 24'd1) begin
                        freq_d  = 1'b1;
                        state_d = S_FRD;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SELECT;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            idx_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            freq_q  <= 1'b0;
            rreq_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            freq_q  <= freq_d;
            rreq_q  <= rreq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BOOT_REGION_COPIER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sum_q <= '0;
        end else if ((state_q == S_IDLE) && START) begin
            sum_q <= '0;
        end else if ((state_q == S_FRD) && FLASH_ACK) begin
            sum_q <= sum_q + {8'h00, FLASH_DATA};
        end
    end

    assign CHECKSUM = sum_q;
`else
    assign CHECKSUM = 16'h0000;
`endif

    assign FLASH_REQ  = freq_q;
    assign FLASH_ADDR = src_q;
    assign RAM_REQ    = rreq_q;
    assign RAM_ADDR   = dst_q;
    assign RAM_DATA   = byte_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign REGION     = idx_q;

endmodule

`default_nettype wire

// File: doc/boot_region_copier.md
Name: boot_region_copier

Overview:
- Boot-time DMA engine that copies a parametrised table of flash regions into SD-RAM. Default table: NEXTOR, FM-BIOS and PAC.
- Sits between the flash reader and the SD-RAM arbiter. Runs once after configuration, before any cartridge function is released.
- Generalises the fixed flash/RAM memory map to REGION_COUNT entries, with a per-region enable mask and progress reporting.

Parameters:
- REGION_COUNT, 3, number of table entries (1..8).
- FLASH_ADDR_LIST, {24'h1F_0000,24'h12_0000,24'h10_0000}, packed 24-bit flash source addresses; entry i is at bits [24i+23:24i].
- RAM_ADDR_LIST, {24'h77_E000,24'h72_0000,24'h70_0000}, packed 24-bit SD-RAM destination addresses.
- SIZE_LIST, {24'h00_2000,24'h00_4000,24'h02_0000}, packed 24-bit byte counts. A value of 0 means the entry is skipped.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse; begins a copy pass
- REGION_EN  in  REGION_COUNT  per-entry enable; sampled only in the START cycle
- FLASH_REQ  out  1  flash byte-read request
- FLASH_ADDR  out  24  flash byte address
- FLASH_ACK  in  1  one-cycle pulse; FLASH_DATA is valid in this cycle
- FLASH_DATA  in  8  flash read data
- RAM_REQ  out  1  SD-RAM byte-write request
- RAM_ADDR  out  24  SD-RAM byte address
- RAM_DATA  out  8  write data
- RAM_ACK  in  1  one-cycle pulse; write accepted
- BUSY  out  1  high from the cycle after START until the pass completes
- DONE  out  1  sticky; set when a pass completes, cleared by START or RESET
- REGION  out  3  index of the entry currently being copied
- CHECKSUM  out  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States:
  - IDLE: START → SELECT; latch REGION_EN; clear DONE; set BUSY. START while BUSY is ignored.
  - SELECT: scan from index REGION (0 on entry). Skip any entry that is disabled or has size 0, one entry per cycle. On reaching a valid entry, load src/dst/count and go to FRD. Past the last entry, go to FIN.
  - FRD: FLASH_REQ=1 and FLASH_ADDR=src, both held stable until FLASH_ACK. In the ACK cycle N, capture FLASH_DATA. In cycle N+1: FLASH_REQ=0, RAM_REQ=1, RAM_ADDR=dst, RAM_DATA=byte.
  - RWR: hold RAM_REQ, RAM_ADDR and RAM_DATA until RAM_ACK. In the ACK cycle M: src+1, dst+1, count-1. In cycle M+1: RAM_REQ=0. If count is still nonzero, FLASH_REQ=1 in that same cycle (FRD). Otherwise REGION+1 and go to SELECT.
  - FIN: BUSY=0, DONE=1 in the same cycle; then IDLE.
- FLASH_REQ and RAM_REQ are never high together.
- An ACK that arrives while its REQ is low is ignored.
- Address arithmetic is modulo 2^24: 24'hFF_FFFF+1 wraps to 0, and no error is flagged.
- count is 24 bits, so the maximum region size is 24'hFF_FFFF bytes.
- Minimum throughput: 2 cycles per byte with zero-wait ACKs (ACK in the first REQ cycle).
- If REGION_EN is all zero (or every size is 0), the pass runs SELECT for REGION_COUNT cycles, then FIN. No bus requests are issued.
- RESET mid-transfer: at the next edge all outputs are 0 and the state is IDLE. An outstanding request is dropped without waiting for its ACK. Downstream logic tolerates a request that is abandoned this way.
- REGION holds the last index after FIN until the next START.

Optional Feature:
- Macro: BOOT_REGION_COPIER_CHECKSUM_EN.
- Defined:
  - CHECKSUM is a 16-bit wrap-around sum of every byte captured during the pass, zero-extended.
  - It is cleared at START and updated in each FLASH_ACK cycle.
  - It is valid when DONE=1, for firmware comparison against a stored sum.
- Not defined: CHECKSUM is tied to 0 and no adder is generated.

Test Plan:
- Default table, REGION_EN=3'b111, zero-wait ACKs:
  - exactly 0x26000 flash reads and RAM writes occur;
  - the first write is RAM_ADDR 70_0000 and the last is 77_FFFF;
  - DONE rises and BUSY falls in the same cycle.
- REGION_EN=3'b010: only the FM entry is copied, 12_0000→72_0000, 0x4000 bytes; REGION=1 during the transfer.
- Random ACK delays of 0–7 cycles:
  - REQ, ADDR and DATA stay stable while waiting;
  - FLASH_REQ and RAM_REQ are never both high;
  - the RAM model content matches the flash model.
- Entry with FLASH_ADDR FF_FFFE and size 4: reads hit FF_FFFE, FF_FFFF, 00_0000, 00_0001 in that order.
- RESET asserted while RAM_REQ=1 mid-region:
  - next cycle all outputs are 0;
  - a RAM_ACK one cycle later is ignored;
  - a new START restarts from region 0.
- With BOOT_REGION_COPIER_CHECKSUM_EN, one region of 4 bytes 0xFF: CHECKSUM=16'h03FC at DONE. Without the macro, CHECKSUM=0 throughout.
